execution_controller: RTL and testbench

Run/step controller for the CPU core. It drives the program counter's advance enable and reacts to HALT. It also serializes a PC and cycle-count report toward the debug UART transmitter. It is the controlling side of the PC interface: the PC consumes `enable`, and this block decides when it is asserted and reads the PC value back.

---
 rtl/debug_pkg.sv | 26 ++
 rtl/execution_controller_if.sv | 27 ++
 rtl/execution_controller_report_serializer.sv | 54 +++++
 rtl/execution_controller.sv | 98 +++++++++
 tb/tb_execution_controller.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared debug-controller definitions: command codes, FSM states and report geometry.
package debug_pkg;

  localparam logic [7:0] CMD_RUN    = 8'h52;
  localparam logic [7:0] CMD_STEP   = 8'h53;
  localparam logic [7:0] CMD_REPORT = 8'h50;

  localparam int REPORT_BYTES = 4;
  localparam int RPT_W        = 8 * REPORT_BYTES;
  localparam int IDX_W        = $clog2(REPORT_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SEND   = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  // Saturating increment: the report format has no room for a wrapped count.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/execution_controller_if.sv
// Debug/run-control bundle between the execution controller and the core + UART side.
interface execution_controller_if #(
  parameter int MSB = 11
) ();

  logic [7:0]     i_cmd;
  logic           i_cmd_valid;
  logic [MSB-1:0] i_pc;
  logic           i_halt;
  logic           o_pc_enable;
  logic [7:0]     o_tx_data;
  logic           o_tx_valid;
  logic           i_tx_ready;
  logic           o_busy;
  logic           o_halted;

  modport master (
    input  i_cmd, i_cmd_valid, i_pc, i_halt, i_tx_ready,
    output o_pc_enable, o_tx_data, o_tx_valid, o_busy, o_halted
  );

  modport slave (
    output i_cmd, i_cmd_valid, i_pc, i_halt, i_tx_ready,
    input  o_pc_enable, o_tx_data, o_tx_valid, o_busy, o_halted
  );

endinterface

// File: rtl/execution_controller_report_serializer.sv
// Shifts a 32-bit PC/count report out MSB-first as bytes over a valid/ready handshake.
module report_serializer
  import debug_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             load_i,
  input  logic [RPT_W-1:0] data_i,
  input  logic             tx_ready_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  output logic             done_o
);

  logic [RPT_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             xfer;

  assign xfer   = vld_q & tx_ready_i;
  assign done_o = xfer & (idx_q == IDX_W'(REPORT_BYTES - 1));

  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    if (load_i) begin
      sreg_d = data_i;
      idx_d  = '0;
      vld_d  = 1'b1;
    end else if (xfer) begin
      sreg_d = sreg_q << 8;
      idx_d  = idx_q + 1'b1;
      if (done_o) vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sreg_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
    end
  end

  // Head byte is presented directly; it only moves on an accepted transfer.
  assign tx_data_o  = sreg_q[RPT_W-1 -: 8];
  assign tx_valid_o = vld_q;

endmodule

// File: rtl/execution_controller.sv
// Run/step/halt control for the core PC plus PC/cycle-count report toward the debug UART.
module execution_controller
  import debug_pkg::*;
#(
  parameter int MSB   = 11,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  execution_controller_if.master dbg
);

  state_e           state_q, state_d;
  logic             pc_en_q, pc_en_d;
  logic             halt_seen_q, halt_seen_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ser_load, ser_done;
  logic [RPT_W-1:0] rpt_word;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state: commands are judged against the current state only
  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (dbg.i_cmd_valid) begin
          case (dbg.i_cmd)
            CMD_RUN:    state_d = ST_RUN;
            CMD_STEP:   state_d = ST_STEP;
            CMD_REPORT: state_d = ST_LOAD;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (dbg.i_halt) begin
          halt_seen_d = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_STEP: begin
        if (dbg.i_halt) halt_seen_d = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (ser_done) state_d = halt_seen_q ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        if (dbg.i_cmd_valid && dbg.i_cmd == CMD_REPORT) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs; enable is registered from the next state so it tracks RUN/STEP exactly
  always_comb begin
    pc_en_d      = (state_d == ST_RUN) || (state_d == ST_STEP);
    ser_load     = (state_q == ST_LOAD);
    dbg.o_busy   = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    dbg.o_halted = (state_q == ST_HALTED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_en_q     <= 1'b0;
      halt_seen_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pc_en_q     <= pc_en_d;
      halt_seen_q <= halt_seen_d;
      if (pc_en_q) cnt_q <= sat_inc16(cnt_q);
    end
  end

  assign dbg.o_pc_enable = pc_en_q;

  // PC zero-extended to 16 bits in the high half, cycle count in the low half
  assign rpt_word = {16'(dbg.i_pc), cnt_q};

  report_serializer u_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .load_i     (ser_load),
    .data_i     (rpt_word),
    .tx_ready_i (dbg.i_tx_ready),
    .tx_data_o  (dbg.o_tx_data),
    .tx_valid_o (dbg.o_tx_valid),
    .done_o     (ser_done)
  );

endmodule

// File: tb/tb_execution_controller.sv
// Self-checking bench for execution_controller: command table, directed corner cases, random ops vs. model.
module tb_execution_controller;
  import debug_pkg::*;

  localparam int MSB = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execution_controller_if #(.MSB(MSB)) dbg ();

  execution_controller #(.MSB(MSB), .CNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .dbg   (dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: integer cycle count, bench-side PC, halt bookkeeping
  int             m_cnt;
  logic           m_hs;
  logic           m_halted;
  logic [MSB-1:0] m_pc;

  typedef struct {
    logic [7:0] cmd;
    logic       vld;
    logic       exp_en;
    logic       exp_busy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_report();
    int c;
    c = (m_cnt > 65535) ? 65535 : m_cnt;
    return {16'(m_pc), 16'(c)};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    dbg.i_cmd_valid = 1'b0;
    dbg.i_halt      = 1'b0;
    dbg.i_tx_ready  = 1'b0;
    tick;
    chk("rst_en",     32'(dbg.o_pc_enable), 0);
    chk("rst_txv",    32'(dbg.o_tx_valid),  0);
    chk("rst_txd",    32'(dbg.o_tx_data),   0);
    chk("rst_busy",   32'(dbg.o_busy),      0);
    chk("rst_halted", 32'(dbg.o_halted),    0);
    tick;
    rst = 1'b0;
    m_cnt = 0; m_hs = 1'b0; m_halted = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    dbg.i_cmd       = c;
    dbg.i_cmd_valid = 1'b1;
    dbg.i_halt      = 1'($urandom_range(0, 1));
    tick;
    dbg.i_cmd_valid = 1'b0;
    dbg.i_halt      = 1'b0;
  endtask

  task automatic do_step(input bit h);
    send_cmd(CMD_STEP);
    chk("step_en",   32'(dbg.o_pc_enable), 1);
    chk("step_busy", 32'(dbg.o_busy),      1);
    dbg.i_halt = h;
    tick;
    dbg.i_halt = 1'b0;
    m_pc++; dbg.i_pc = m_pc; m_cnt++; m_hs = m_hs | h;
    chk("step_en_off", 32'(dbg.o_pc_enable), 0);
  endtask

  task automatic do_run(input int k);
    send_cmd(CMD_RUN);
    for (int i = 1; i <= k; i++) begin
      chk("run_en", 32'(dbg.o_pc_enable), 1);
      dbg.i_halt = (i == k);
      tick;
      m_pc++; dbg.i_pc = m_pc; m_cnt++;
    end
    dbg.i_halt = 1'b0;
    m_hs = 1'b1;
    chk("run_en_off", 32'(dbg.o_pc_enable), 0);
  endtask

  // Called in the LOAD cycle. stall[i]=1 drops ready on the i-th valid cycle.
  task automatic get_report(input logic [15:0] stall, input bit rnd, input bit junk,
                            output logic [31:0] got, output int ncyc);
    logic [7:0] held;
    logic [7:0] jc [3];
    bit         pend;
    bit         rdy;
    int         nb, cyc, vcyc;
    jc[0] = CMD_RUN; jc[1] = CMD_STEP; jc[2] = CMD_REPORT;
    got = '0; held = '0; pend = 1'b0; nb = 0; cyc = 0; vcyc = 0;
    while (nb < 4 && cyc < 200) begin
      chk("rpt_en_off", 32'(dbg.o_pc_enable), 0);
      chk("rpt_busy",   32'(dbg.o_busy),      1);
      if (cyc >= 1) chk("tx_vld", 32'(dbg.o_tx_valid), 1);
      if (pend) chk("tx_hold", 32'(dbg.o_tx_data), 32'(held));
      dbg.i_halt      = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      dbg.i_cmd_valid = junk && ($urandom_range(0, 2) == 0);
      dbg.i_cmd       = jc[$urandom_range(0, 2)];
      if (rnd)            rdy = ($urandom_range(0, 3) != 0);
      else if (vcyc < 16) rdy = !stall[vcyc];
      else                rdy = 1'b1;
      dbg.i_tx_ready = rdy;
      if (dbg.o_tx_valid) begin
        vcyc++;
        if (rdy) begin
          got = {got[23:0], dbg.o_tx_data};
          nb++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = dbg.o_tx_data;
        end
      end
      tick;
      cyc++;
    end
    dbg.i_cmd_valid = 1'b0;
    dbg.i_halt      = 1'b0;
    dbg.i_tx_ready  = 1'b0;
    ncyc = cyc;
    if (nb < 4) chk("rpt_timeout", 32'(nb), 4);
    chk("txv_after",    32'(dbg.o_tx_valid), 0);
    chk("busy_after",   32'(dbg.o_busy),     0);
    chk("halted_after", 32'(dbg.o_halted),   32'(m_hs));
    m_halted = m_hs;
  endtask

  task automatic chk_ignored(input string nm);
    chk({nm, "_en"},     32'(dbg.o_pc_enable), 0);
    chk({nm, "_busy"},   32'(dbg.o_busy),      0);
    chk({nm, "_halted"}, 32'(dbg.o_halted),    32'(m_halted));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    logic [31:0] got;
    logic [7:0]  c;
    int          nc, op;

    tbl[0] = '{8'h52, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{8'h53, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8'h50, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h72, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h52, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'h51, 1'b1, 1'b0, 1'b0};

    m_pc = '0;
    dbg.i_pc = m_pc; dbg.i_cmd = '0; dbg.i_cmd_valid = 1'b0;
    dbg.i_halt = 1'b0; dbg.i_tx_ready = 1'b0;

    // command decode from IDLE, one reset per vector (also resets out of RUN)
    for (int i = 0; i < 8; i++) begin
      do_reset;
      dbg.i_cmd = tbl[i].cmd;
      dbg.i_cmd_valid = tbl[i].vld;
      tick;
      dbg.i_cmd_valid = 1'b0;
      chk("tbl_en",     32'(dbg.o_pc_enable), 32'(tbl[i].exp_en));
      chk("tbl_busy",   32'(dbg.o_busy),      32'(tbl[i].exp_busy));
      chk("tbl_halted", 32'(dbg.o_halted),    0);
    end

    // report of a zero PC, ready held high
    do_reset;
    m_pc = '0; dbg.i_pc = m_pc;
    send_cmd(CMD_REPORT);
    get_report(16'h0, 1'b0, 1'b0, got, nc);
    chk("p_zero", got, 32'h0000_0000);
    chk("p_consec", 32'(nc), 5);

    // single step from 0x004
    do_reset;
    m_pc = 11'h004; dbg.i_pc = m_pc;
    do_step(1'b0);
    get_report(16'h0, 1'b0, 1'b0, got, nc);
    chk("step_rpt", got, 32'h0005_0001);

    // run 10 cycles then HALT
    do_reset;
    m_pc = '0; dbg.i_pc = m_pc;
    do_run(10);
    get_report(16'h0, 1'b0, 1'b0, got, nc);
    chk("run_rpt", got, 32'h000A_000A);
    send_cmd(CMD_RUN);
    chk_ignored("halt_r");
    send_cmd(CMD_STEP);
    chk_ignored("halt_s");

    // report from HALTED with ready low for 3 cycles on byte 2
    send_cmd(CMD_REPORT);
    get_report(16'h000E, 1'b0, 1'b0, got, nc);
    chk("stall_rpt", got, 32'h000A_000A);
    chk("stall_cyc", 32'(nc), 8);

    // commands and HALT during a report are dropped
    do_reset;
    m_pc = 11'h123; dbg.i_pc = m_pc;
    send_cmd(CMD_REPORT);
    get_report(16'h0, 1'b1, 1'b1, got, nc);
    chk("junk_rpt", got, 32'h0123_0000);

    // random operations against the model
    do_reset;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          send_cmd(CMD_REPORT);
          get_report(16'h0, 1'b1, 1'($urandom_range(0, 1)), got, nc);
          chk("rnd_p", got, exp_report());
        end
        1: begin
          if (m_halted) begin
            send_cmd(CMD_STEP);
            chk_ignored("rnd_hs");
          end else begin
            do_step($urandom_range(0, 3) == 0);
            get_report(16'h0, 1'b1, 1'($urandom_range(0, 1)), got, nc);
            chk("rnd_s", got, exp_report());
          end
        end
        2: begin
          if (m_halted) begin
            send_cmd(CMD_RUN);
            chk_ignored("rnd_hr");
          end else begin
            do_run($urandom_range(1, 25));
            get_report(16'h0, 1'b1, 1'($urandom_range(0, 1)), got, nc);
            chk("rnd_r", got, exp_report());
          end
        end
        3: begin
          c = 8'($urandom_range(0, 255));
          if (c == CMD_RUN || c == CMD_STEP || c == CMD_REPORT) c = 8'h41;
          send_cmd(c);
          chk_ignored("rnd_junk");
        end
        4: begin
          dbg.i_halt = 1'($urandom_range(0, 1));
          tick;
          dbg.i_halt = 1'b0;
          chk_ignored("rnd_idle");
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset;
        end
      endcase
    end

    // saturating count, then reset in the middle of a report
    do_reset;
    m_pc = '0; dbg.i_pc = m_pc;
    do_run(65540);
    get_report(16'h0, 1'b0, 1'b0, got, nc);
    chk("sat_cnt", 32'(got[15:0]), 32'h0000_FFFF);
    chk("sat_rpt", got, exp_report());
    send_cmd(CMD_REPORT);
    tick;
    chk("mid_vld", 32'(dbg.o_tx_valid), 1);
    dbg.i_tx_ready = 1'b1;
    tick;
    dbg.i_tx_ready = 1'b0;
    chk("mid_vld2", 32'(dbg.o_tx_valid), 1);
    rst = 1'b1;
    tick;
    chk("mid_rst_txv",    32'(dbg.o_tx_valid),  0);
    chk("mid_rst_txd",    32'(dbg.o_tx_data),   0);
    chk("mid_rst_busy",   32'(dbg.o_busy),      0);
    chk("mid_rst_halted", 32'(dbg.o_halted),    0);
    chk("mid_rst_en",     32'(dbg.o_pc_enable), 0);
    rst = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
